// File: rtl/parking_gate_arbiter.sv
// Entrance/exit gate arbiter: one arm moves at a time, with minimum open time, timeout and settle gap.
// Optional statistics counters are built when PARKING_GATE_STATS_EN is defined.
module parking_gate_arbiter #(
  parameter int NUM_SPOTS       = 3,
  parameter int OPEN_MIN_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 50000000,
  parameter int SETTLE_CYCLES   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 entr_wait,
  input  logic                 exit_wait,
  input  logic [NUM_SPOTS-1:0] pp,
  output logic                 entr_open,
  output logic                 exit_open,
  output logic                 led_full,
  output logic                 car_entered,
  output logic                 car_exited,
  output logic                 timeout_err,
  output logic                 busy
`ifdef PARKING_GATE_STATS_EN
  ,
  output logic [15:0]          entry_count,
  output logic [15:0]          exit_count,
  output logic [7:0]           timeout_count
`endif
);

  // One timer serves both the open phase and the settle phase, so it is sized for the longer one.
  localparam int TIMER_MAX = (TIMEOUT_CYCLES > SETTLE_CYCLES) ? TIMEOUT_CYCLES : SETTLE_CYCLES;
  localparam int TW        = $clog2(TIMER_MAX + 1);

  localparam logic [TW-1:0] OPEN_MIN_LAST = TW'(OPEN_MIN_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] SETTLE_LAST   = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_SAT     = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ENTR = 2'd1,
    EXIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  typedef enum logic {
    GRANT_ENTR = 1'b0,
    GRANT_EXIT = 1'b1
  } grant_t;

  state_t        state;
  state_t        next_state;
  grant_t        last_grant;
  grant_t        grant_side;
  logic [TW-1:0] timer;

  logic lot_full;
  logic entr_req;
  logic exit_req;
  logic gate_wait;
  logic grant_valid;
  logic close_normal;
  logic close_timeout;

  assign lot_full = &pp;
  assign led_full = lot_full;
  assign entr_req = entr_wait & ~lot_full;
  assign exit_req = exit_wait;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state    = state;
    grant_valid   = 1'b0;
    grant_side    = GRANT_ENTR;
    close_normal  = 1'b0;
    close_timeout = 1'b0;
    gate_wait     = (state == EXIT) ? exit_wait : entr_wait;
    case (state)
      IDLE: begin
        if (entr_req && exit_req) begin
          grant_valid = 1'b1;
          grant_side  = (last_grant == GRANT_ENTR) ? GRANT_EXIT : GRANT_ENTR;
        end else if (entr_req) begin
          grant_valid = 1'b1;
          grant_side  = GRANT_ENTR;
        end else if (exit_req) begin
          grant_valid = 1'b1;
          grant_side  = GRANT_EXIT;
        end
        if (grant_valid) begin
          next_state = (grant_side == GRANT_EXIT) ? EXIT : ENTR;
        end
      end
      ENTR, EXIT: begin
        // A clean pass takes priority over a timeout landing on the same edge.
        if (!gate_wait && (timer >= OPEN_MIN_LAST)) begin
          close_normal = 1'b1;
          next_state   = HOLD;
        end else if (timer == TIMEOUT_LAST) begin
          close_timeout = 1'b1;
          next_state    = HOLD;
        end
      end
      HOLD: begin
        if (timer >= SETTLE_LAST) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_comb begin
    entr_open = (state == ENTR);
    exit_open = (state == EXIT);
    busy      = (state != IDLE);
  end

  // Timer restarts at every state change and saturates rather than wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer <= '0;
    end else if ((next_state != state) || (state == IDLE)) begin
      timer <= '0;
    end else if (timer != TIMER_SAT) begin
      timer <= timer + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= GRANT_ENTR;
    end else if (grant_valid) begin
      last_grant <= grant_side;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      car_entered <= 1'b0;
      car_exited  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      car_entered <= close_normal && (state == ENTR);
      car_exited  <= close_normal && (state == EXIT);
      timeout_err <= timeout_err | close_timeout;
    end
  end

`ifdef PARKING_GATE_STATS_EN
  // Counters advance on the same edge that launches the matching pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      entry_count   <= '0;
      exit_count    <= '0;
      timeout_count <= '0;
    end else begin
      if (close_normal && (state == ENTR) && (entry_count != 16'hFFFF)) begin
        entry_count <= entry_count + 16'd1;
      end
      if (close_normal && (state == EXIT) && (exit_count != 16'hFFFF)) begin
        exit_count <= exit_count + 16'd1;
      end
      if (close_timeout && (timeout_count != 8'hFF)) begin
        timeout_count <= timeout_count + 8'd1;
      end
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Self-checking bench for parking_gate_arbiter: directed scenarios plus randomized traffic
// compared cycle by cycle against a behavioural model of the gate rules.
module tb_parking_gate_arbiter;

  localparam int NS = 3;
  localparam int OM = 2;
  localparam int TO = 8;
  localparam int ST = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          entr_wait;
  logic          exit_wait;
  logic [NS-1:0] pp;
  logic          entr_open;
  logic          exit_open;
  logic          led_full;
  logic          car_entered;
  logic          car_exited;
  logic          timeout_err;
  logic          busy;
`ifdef PARKING_GATE_STATS_EN
  logic [15:0]   entry_count;
  logic [15:0]   exit_count;
  logic [7:0]    timeout_count;
`endif

  parking_gate_arbiter #(
    .NUM_SPOTS(NS),
    .OPEN_MIN_CYCLES(OM),
    .TIMEOUT_CYCLES(TO),
    .SETTLE_CYCLES(ST)
  ) dut (
    .clk(clk),
    .reset(reset),
    .entr_wait(entr_wait),
    .exit_wait(exit_wait),
    .pp(pp),
    .entr_open(entr_open),
    .exit_open(exit_open),
    .led_full(led_full),
    .car_entered(car_entered),
    .car_exited(car_exited),
    .timeout_err(timeout_err),
    .busy(busy)
`ifdef PARKING_GATE_STATS_EN
    ,
    .entry_count(entry_count),
    .exit_count(exit_count),
    .timeout_count(timeout_count)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: which gate holds the actuator (0 none, 1 entrance, 2 exit, 3 settling)
  // and how many cycles that phase has lasted, counting the current one.
  int m_phase;
  int m_elapsed;
  bit m_prev_exit;
  bit m_entered;
  bit m_exited;
  bit m_terr;
  int m_ecnt;
  int m_xcnt;
  int m_tcnt;

  task automatic model_edge();
    bit er;
    bit xr;
    bit w;
    if (reset) begin
      m_phase = 0; m_elapsed = 0; m_prev_exit = 0;
      m_entered = 0; m_exited = 0; m_terr = 0;
      m_ecnt = 0; m_xcnt = 0; m_tcnt = 0;
    end else begin
      m_entered = 0;
      m_exited  = 0;
      case (m_phase)
        0: begin
          er = entr_wait && !(&pp);
          xr = exit_wait;
          if (er && xr) m_phase = m_prev_exit ? 1 : 2;
          else if (er) m_phase = 1;
          else if (xr) m_phase = 2;
          if (m_phase != 0) begin
            m_prev_exit = (m_phase == 2);
            m_elapsed = 1;
          end
        end
        1, 2: begin
          w = (m_phase == 1) ? entr_wait : exit_wait;
          if (!w && m_elapsed >= OM) begin
            if (m_phase == 1) begin m_entered = 1; if (m_ecnt < 65535) m_ecnt++; end
            else begin m_exited = 1; if (m_xcnt < 65535) m_xcnt++; end
            m_phase = 3; m_elapsed = 1;
          end else if (m_elapsed == TO) begin
            m_terr = 1;
            if (m_tcnt < 255) m_tcnt++;
            m_phase = 3; m_elapsed = 1;
          end else begin
            m_elapsed++;
          end
        end
        default: begin
          if (m_elapsed >= ST) begin m_phase = 0; m_elapsed = 0; end
          else m_elapsed++;
        end
      endcase
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int n;
    entr_wait = 0; exit_wait = 0;
    n = 0;
    while (busy && n < 100) begin step(); n++; end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s_drain busy=%b after %0d cycles, want 0", tag, busy, n);
    end
  endtask

  task automatic do_reset();
    reset = 1; step(); step(); reset = 0;
  endtask

  task automatic test_reset();
    entr_wait = 0; exit_wait = 0; pp = '0;
    do_reset();
    checks += 5;
    if (entr_open !== 1'b0) begin errors++; $display("[TB] FAIL reset_entr_open got %b want 0", entr_open); end
    if (exit_open !== 1'b0) begin errors++; $display("[TB] FAIL reset_exit_open got %b want 0", exit_open); end
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    if (timeout_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_timeout_err got %b want 0", timeout_err); end
    if ({car_entered, car_exited} !== 2'b00) begin
      errors++; $display("[TB] FAIL reset_pulses got %b%b want 00", car_entered, car_exited);
    end
  endtask

  task automatic test_single_entry();
    int opened;
    int pulses;
    int bad_pulse;
    int exit_seen;
    opened = 0; pulses = 0; bad_pulse = 0; exit_seen = 0;
    pp = '0; entr_wait = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (entr_open) opened++;
      if (exit_open) exit_seen++;
    end
    entr_wait = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (entr_open) opened++;
      if (exit_open) exit_seen++;
      if (car_entered) begin pulses++; if (entr_open) bad_pulse++; end
    end
    checks += 5;
    if (opened != 6) begin errors++; $display("[TB] FAIL single_open_cycles got %0d want 6", opened); end
    if (pulses != 1) begin errors++; $display("[TB] FAIL single_entered_pulses got %0d want 1", pulses); end
    if (bad_pulse != 0) begin errors++; $display("[TB] FAIL single_pulse_while_open got %0d want 0", bad_pulse); end
    if (exit_seen != 0) begin errors++; $display("[TB] FAIL single_exit_opened got %0d want 0", exit_seen); end
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL single_busy_end got %b want 0", busy); end
  endtask

  task automatic test_simultaneous();
    int entr_rise;
    int overlap;
    do_reset();
    pp = '0; entr_wait = 1; exit_wait = 1;
    step();
    checks += 2;
    if (exit_open !== 1'b1) begin errors++; $display("[TB] FAIL tie_exit_first got %b want 1", exit_open); end
    if (entr_open !== 1'b0) begin errors++; $display("[TB] FAIL tie_entr_held got %b want 0", entr_open); end
    exit_wait = 0;
    entr_rise = -1; overlap = 0;
    for (int i = 2; i <= 20; i++) begin
      step();
      if (entr_open && exit_open) overlap++;
      if (entr_open && entr_rise < 0) entr_rise = i;
    end
    checks += 2;
    if (entr_rise != 1 + OM + ST + 1) begin
      errors++; $display("[TB] FAIL tie_entr_grant_cycle got %0d want %0d", entr_rise, 1 + OM + ST + 1);
    end
    if (overlap != 0) begin errors++; $display("[TB] FAIL tie_overlap got %0d want 0", overlap); end
    drain("tie");
  endtask

  task automatic test_full_lot();
    int entr_seen;
    int exit_seen;
    int full_bad;
    int overlap;
    entr_seen = 0; exit_seen = 0; full_bad = 0; overlap = 0;
    pp = 3'b111; entr_wait = 1; exit_wait = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (entr_open) entr_seen++;
      if (led_full !== 1'b1) full_bad++;
    end
    checks += 2;
    if (entr_seen != 0) begin errors++; $display("[TB] FAIL full_entr_opened got %0d want 0", entr_seen); end
    if (full_bad != 0) begin errors++; $display("[TB] FAIL full_led got %0d low cycles want 0", full_bad); end
    exit_wait = 1; step(); exit_wait = 0;
    if (exit_open) exit_seen++;
    for (int i = 0; i < 8; i++) begin
      step();
      if (exit_open) exit_seen++;
      if (entr_open) entr_seen++;
    end
    checks += 2;
    if (exit_seen != OM) begin errors++; $display("[TB] FAIL full_exit_cycles got %0d want %0d", exit_seen, OM); end
    if (entr_seen != 0) begin errors++; $display("[TB] FAIL full_entr_during_exit got %0d want 0", entr_seen); end
    pp = 3'b110;
    for (int i = 0; i < 6; i++) begin
      step();
      if (entr_open) entr_seen++;
      if (entr_open && exit_open) overlap++;
    end
    checks += 3;
    if (entr_seen == 0) begin errors++; $display("[TB] FAIL full_entr_after_space got 0 open cycles want >0"); end
    if (led_full !== 1'b0) begin errors++; $display("[TB] FAIL full_led_cleared got %b want 0", led_full); end
    if (overlap != 0) begin errors++; $display("[TB] FAIL full_overlap got %0d want 0", overlap); end
    drain("full");
  endtask

  task automatic test_short_wait();
    int opened;
    int pulses;
    int bad_pulse;
    opened = 0; pulses = 0; bad_pulse = 0;
    pp = '0; exit_wait = 1;
    step();
    if (exit_open) opened++;
    exit_wait = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (exit_open) opened++;
      if (car_exited) begin pulses++; if (exit_open) bad_pulse++; end
    end
    checks += 3;
    if (opened != OM) begin errors++; $display("[TB] FAIL short_open_cycles got %0d want %0d", opened, OM); end
    if (pulses != 1) begin errors++; $display("[TB] FAIL short_exited_pulses got %0d want 1", pulses); end
    if (bad_pulse != 0) begin errors++; $display("[TB] FAIL short_pulse_while_open got %0d want 0", bad_pulse); end
  endtask

  task automatic test_timeout();
    int rises[4];
    int n;
    int run1;
    int pulses;
    logic prev;
    do_reset();
    n = 0; run1 = 0; pulses = 0; prev = 0;
    pp = '0; entr_wait = 1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (entr_open && !prev && n < 4) begin rises[n] = i; n++; end
      if (entr_open && n == 1) run1++;
      if (car_entered) pulses++;
      prev = entr_open;
    end
    checks += 4;
    if (run1 != TO) begin errors++; $display("[TB] FAIL timeout_open_cycles got %0d want %0d", run1, TO); end
    if (pulses != 0) begin errors++; $display("[TB] FAIL timeout_entered_pulses got %0d want 0", pulses); end
    if (timeout_err !== 1'b1) begin errors++; $display("[TB] FAIL timeout_err_set got %b want 1", timeout_err); end
    if (n < 2 || rises[1] != 1 + TO + ST + 1) begin
      errors++; $display("[TB] FAIL timeout_regrant_cycle got %0d grants (second at %0d) want second at %0d",
                         n, (n >= 2) ? rises[1] : -1, 1 + TO + ST + 1);
    end
    drain("timeout");
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (timeout_err !== 1'b1) begin errors++; $display("[TB] FAIL timeout_err_sticky got %b want 1", timeout_err); end
  endtask

  task automatic test_reset_mid_open();
    pp = '0; entr_wait = 1;
    step(); step(); step();
    checks++;
    if (entr_open !== 1'b1) begin errors++; $display("[TB] FAIL midreset_pre_open got %b want 1", entr_open); end
    reset = 1;
    step();
    checks += 4;
    if (entr_open !== 1'b0) begin errors++; $display("[TB] FAIL midreset_entr_open got %b want 0", entr_open); end
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_busy got %b want 0", busy); end
    if (car_entered !== 1'b0) begin errors++; $display("[TB] FAIL midreset_pulse got %b want 0", car_entered); end
    if (timeout_err !== 1'b0) begin errors++; $display("[TB] FAIL midreset_timeout_err got %b want 0", timeout_err); end
`ifdef PARKING_GATE_STATS_EN
    checks++;
    if ({entry_count, exit_count, timeout_count} !== 40'd0) begin
      errors++; $display("[TB] FAIL midreset_counters got %0d/%0d/%0d want 0/0/0", entry_count, exit_count, timeout_count);
    end
`endif
    reset = 0; entr_wait = 0;
    step();
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) entr_wait = ~entr_wait;
      if ($urandom_range(0, 5) == 0) exit_wait = ~exit_wait;
      if ($urandom_range(0, 7) == 0) pp = ($urandom_range(0, 2) == 0) ? 3'b111 : 3'($urandom);
      reset = ($urandom_range(0, 79) == 0);
      step();
      checks++;
      if (led_full !== (&pp)) begin
        errors++; bad++; $display("[TB] FAIL rand_led_full cyc=%0d got %b want %b", i, led_full, &pp);
      end
      checks++;
      if ({entr_open, exit_open, busy} !== {m_phase == 1, m_phase == 2, m_phase != 0}) begin
        errors++; bad++;
        $display("[TB] FAIL rand_gates cyc=%0d got entr=%b exit=%b busy=%b want entr=%b exit=%b busy=%b",
                 i, entr_open, exit_open, busy, m_phase == 1, m_phase == 2, m_phase != 0);
      end
      checks++;
      if ({car_entered, car_exited, timeout_err} !== {m_entered, m_exited, m_terr}) begin
        errors++; bad++;
        $display("[TB] FAIL rand_flags cyc=%0d got entered=%b exited=%b terr=%b want %b %b %b",
                 i, car_entered, car_exited, timeout_err, m_entered, m_exited, m_terr);
      end
      checks++;
      if (entr_open && exit_open) begin
        errors++; bad++; $display("[TB] FAIL rand_overlap cyc=%0d got both open want at most one", i);
      end
`ifdef PARKING_GATE_STATS_EN
      checks++;
      if (entry_count !== 16'(m_ecnt) || exit_count !== 16'(m_xcnt) || timeout_count !== 8'(m_tcnt)) begin
        errors++; bad++;
        $display("[TB] FAIL rand_counters cyc=%0d got %0d/%0d/%0d want %0d/%0d/%0d",
                 i, entry_count, exit_count, timeout_count, m_ecnt, m_xcnt, m_tcnt);
      end
`endif
      if (bad > 20) begin
        $display("[TB] stopping random run early after repeated errors");
        break;
      end
    end
    reset = 0;
    drain("random");
  endtask

  initial begin
    reset = 1; entr_wait = 0; exit_wait = 0; pp = '0;
    test_reset();
    test_single_entry();
    test_simultaneous();
    test_full_lot();
    test_short_wait();
    test_timeout();
    test_reset_mid_open();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
